// File: rtl/ps2_ascii_keyboard.sv
// PS/2 set-2 keyboard receiver: synchronises the keyboard lines, decodes 11-bit frames,
// tracks make/break/extended prefixes and presents the ASCII code of the held key.
module ps2_ascii_keyboard #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned BITS_PER_FRAME = 11;
    localparam int unsigned SYNC_W         = 3;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned SHIFT_W        = BITS_PER_FRAME - 1;
    localparam int unsigned IDLE_W         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BITS_PER_FRAME - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        CODE_EXT  = 8'hE0;
    localparam logic [7:0]        CODE_BRK  = 8'hF0;

    logic [SYNC_W-1:0]  clk_sync_q,  clk_sync_d;
    logic [SYNC_W-1:0]  data_sync_q, data_sync_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [SHIFT_W-1:0] shift_q,     shift_d;
    logic [IDLE_W-1:0]  idle_q,      idle_d;
    logic               ext_q,       ext_d;
    logic               brk_q,       brk_d;
    logic [7:0]         ascii_q,     ascii_d;
    logic [7:0]         scan_q,      scan_d;
    logic               valid_q,     valid_d;
    logic               err_q,       err_d;

    logic                      fall_edge;
    logic                      sample_bit;
    logic [BITS_PER_FRAME-1:0] frame;
    logic [7:0]                frame_byte;
    logic                      frame_ok;
    logic [7:0]                key_ascii;

    // Scan-code set 2 to lowercase ASCII; 0x00 marks an unmapped key.
    function automatic logic [7:0] map_code(input logic [7:0] code);
        logic [7:0] res;
        res = 8'h00;
        case (code)
            8'h1C: res = 8'h61; 8'h32: res = 8'h62; 8'h21: res = 8'h63; 8'h23: res = 8'h64;
            8'h24: res = 8'h65; 8'h2B: res = 8'h66; 8'h34: res = 8'h67; 8'h33: res = 8'h68;
            8'h43: res = 8'h69; 8'h3B: res = 8'h6A; 8'h42: res = 8'h6B; 8'h4B: res = 8'h6C;
            8'h3A: res = 8'h6D; 8'h31: res = 8'h6E; 8'h44: res = 8'h6F; 8'h4D: res = 8'h70;
            8'h15: res = 8'h71; 8'h2D: res = 8'h72; 8'h1B: res = 8'h73; 8'h2C: res = 8'h74;
            8'h3C: res = 8'h75; 8'h2A: res = 8'h76; 8'h1D: res = 8'h77; 8'h22: res = 8'h78;
            8'h35: res = 8'h79; 8'h1A: res = 8'h7A;
            8'h45: res = 8'h30; 8'h16: res = 8'h31; 8'h1E: res = 8'h32; 8'h26: res = 8'h33;
            8'h25: res = 8'h34; 8'h2E: res = 8'h35; 8'h36: res = 8'h36; 8'h3D: res = 8'h37;
            8'h3E: res = 8'h38; 8'h46: res = 8'h39;
            8'h29: res = 8'h20; 8'h5A: res = 8'h0D; 8'h66: res = 8'h08; 8'h76: res = 8'h1B;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    // Frame layout once the 11th bit arrives: [0] start, [8:1] data, [9] parity, [10] stop.
    assign fall_edge  = (clk_sync_q[2:1] == 2'b10);
    assign sample_bit = data_sync_q[2];
    assign frame      = {sample_bit, shift_q};
    assign frame_byte = frame[8:1];
    assign frame_ok   = !frame[0] && (^frame[9:1]) && frame[10];
    assign key_ascii  = map_code(frame_byte);

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[1:0], ps2_data};
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        idle_d      = idle_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        ascii_d     = ascii_q;
        scan_d      = scan_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        if (fall_edge) begin
            idle_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                if (frame_ok) begin
                    scan_d  = frame_byte;
                    valid_d = 1'b1;
                    if (frame_byte == CODE_EXT) begin
                        ext_d = 1'b1;
                    end else if (frame_byte == CODE_BRK) begin
                        brk_d = 1'b1;
                    end else begin
                        // Only a release of the key currently shown clears ascii.
                        if (!ext_q && (key_ascii != 8'h00)) begin
                            if (!brk_q) begin
                                ascii_d = key_ascii;
                            end else if (key_ascii == ascii_q) begin
                                ascii_d = 8'h00;
                            end
                        end
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = {sample_bit, shift_q[SHIFT_W-1:1]};
            end
        end else if (bit_cnt_q != '0) begin
            // Keyboard went quiet mid-frame: drop the partial frame.
            if (idle_q == IDLE_LAST) begin
                bit_cnt_d = '0;
                idle_d    = '0;
                err_d     = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            idle_q      <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            ascii_q     <= 8'h00;
            scan_q      <= 8'h00;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idle_q      <= idle_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            ascii_q     <= ascii_d;
            scan_q      <= scan_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign ascii      = ascii_q;
    assign scan_code  = scan_q;
    assign code_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_ascii_keyboard.sv
// Bench for ps2_ascii_keyboard: drives PS/2 frames and scores each code_valid/frame_err
// event against expectations queued when the frame was sent.
module tb_ps2_ascii_keyboard;

    localparam int unsigned TIMEOUT = 300;
    localparam int unsigned HALF    = 20;

    typedef struct packed {
        logic       err;
        logic [7:0] scan;
        logic [7:0] ascii;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ascii;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    ps2_ascii_keyboard #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ascii     (ascii),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic [7:0] exp_ascii);
        logic [10:0] f;
        exp_t        e;
        f      = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        e.err  = bad_par;
        e.scan = b;
        e.ascii = exp_ascii;
        sb_q.push_back(e);
        send_bits(f, 11);
        wait_cycles(30);
    endtask

    // Monitor: every output event must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (code_valid || frame_err) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_evt", 32'({code_valid, frame_err}), 32'(0));
            end else begin
                e = sb_q.pop_front();
                chk("frame_err", 32'(frame_err), 32'(e.err));
                chk("code_valid", 32'(code_valid), 32'(!e.err));
                if (!e.err) chk("scan_code", 32'(scan_code), 32'(e.scan));
                chk("ascii", 32'(ascii), 32'(e.ascii));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        chk("rst_ascii", 32'(ascii), 32'(8'h00));
        chk("rst_scan", 32'(scan_code), 32'(8'h00));
        chk("rst_valid", 32'(code_valid), 32'(0));
        chk("rst_err", 32'(frame_err), 32'(0));
        rst_n = 1'b1;
        wait_cycles(10);

        // Single make, then release.
        send_frame(8'h1C, 1'b0, 8'h61);
        send_frame(8'hF0, 1'b0, 8'h61);
        send_frame(8'h1C, 1'b0, 8'h00);
        // Enter make/break.
        send_frame(8'h5A, 1'b0, 8'h0D);
        send_frame(8'hF0, 1'b0, 8'h0D);
        send_frame(8'h5A, 1'b0, 8'h00);
        // Bad parity.
        send_frame(8'h1C, 1'b1, 8'h00);
        // Two keys held; releasing the older one keeps the newer.
        send_frame(8'h1C, 1'b0, 8'h61);
        send_frame(8'h32, 1'b0, 8'h62);
        send_frame(8'hF0, 1'b0, 8'h62);
        send_frame(8'h1C, 1'b0, 8'h62);
        send_frame(8'hF0, 1'b0, 8'h62);
        send_frame(8'h32, 1'b0, 8'h00);
        // Typematic repeat, then release.
        send_frame(8'h46, 1'b0, 8'h39);
        send_frame(8'h46, 1'b0, 8'h39);
        send_frame(8'hF0, 1'b0, 8'h39);
        send_frame(8'h46, 1'b0, 8'h00);
        // Extended and unmapped keys leave ascii alone.
        send_frame(8'hE0, 1'b0, 8'h00);
        send_frame(8'h75, 1'b0, 8'h00);
        send_frame(8'h0E, 1'b0, 8'h00);
        // Extended break of a key sharing a code must not clear a held key.
        send_frame(8'h29, 1'b0, 8'h20);
        send_frame(8'hE0, 1'b0, 8'h20);
        send_frame(8'hF0, 1'b0, 8'h20);
        send_frame(8'h29, 1'b0, 8'h20);
        send_frame(8'hF0, 1'b0, 8'h20);
        send_frame(8'h29, 1'b0, 8'h00);

        // Partial frame followed by silence times out.
        begin
            exp_t e;
            e.err = 1'b1; e.scan = 8'h00; e.ascii = 8'h00;
            sb_q.push_back(e);
            send_bits(11'b111_0110_1100, 5);
            wait_cycles(TIMEOUT + 60);
        end
        send_frame(8'h16, 1'b0, 8'h31);

        // Reset mid-frame with a pending break prefix clears everything.
        send_frame(8'hF0, 1'b0, 8'h31);
        send_bits(11'b111_0101_0100, 4);
        rst_n = 1'b0;
        wait_cycles(3);
        chk("mid_rst_ascii", 32'(ascii), 32'(8'h00));
        chk("mid_rst_scan", 32'(scan_code), 32'(8'h00));
        rst_n = 1'b1;
        wait_cycles(10);
        send_frame(8'h16, 1'b0, 8'h31);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) wait_cycles(1);
        chk("sb_drain", 32'(sb_q.size()), 32'(0));
        chk("final_ascii", 32'(ascii), 32'(8'h31));
        chk("final_scan", 32'(scan_code), 32'(8'h16));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
